jtvigil_dwnld: RTL and testbench

Converts the byte-wide ROM download stream (ioctl) into word-wide SDRAM programming requests for the four SDRAM banks. It sits between the frame loader and the SDRAM arbiter and drives the prog_* bus. A one-entry buffer absorbs bytes that arrive while a write is in flight. Bytes in the colour-PROM region are diverted to a separate write strobe instead of SDRAM.

---
 rtl/jtvigil_dwnld_pkg.sv | 42 ++++
 rtl/jtvigil_dwnld_map.sv | 58 +++++
 rtl/jtvigil_dwnld.sv | 236 +++++++++++++++++++++++
 tb/tb_jtvigil_dwnld.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtvigil_dwnld_pkg.sv
// ---------------------------------------------------------------------------
// jtvigil_dwnld_pkg
// Shared types for the ROM download to SDRAM converter:
//   state_t     - request FSM states
//   region_t    - download address regions (four SDRAM banks, PROM, discard)
//   wr_req_t    - one pending SDRAM byte write (bank, word address, byte, lane)
//   PROM_SIZE   - size in bytes of the colour-PROM region
//   lane_mask() - byte lane to active-high "do not write" mask
// ---------------------------------------------------------------------------
package jtvigil_dwnld_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // The SDRAM banks come first so "region <= RG_BA3" means "goes to SDRAM".
  typedef enum logic [2:0] {
    RG_BA0  = 3'd0,
    RG_BA1  = 3'd1,
    RG_BA2  = 3'd2,
    RG_BA3  = 3'd3,
    RG_PROM = 3'd4,
    RG_DROP = 3'd5
  } region_t;

  localparam int unsigned PROM_SIZE = 1024;

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [7:0]  data;
    logic        lane;   // 0 = low byte, 1 = high byte
  } wr_req_t;

  // The byte goes on the lane named by the offset LSB, the other lane is masked.
  function automatic logic [1:0] lane_mask(input logic lane);
    return lane ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/jtvigil_dwnld_map.sv
// ---------------------------------------------------------------------------
// jtvigil_dwnld_map
// Combinational decode of a download byte address into its region, SDRAM
// bank and byte offset relative to the start of that region.
//   addr   in  25  ioctl byte address
//   region out 3   region_t code (banks 0..3, PROM, drop)
//   ba     out 2   SDRAM bank (0 for PROM/drop)
//   offset out 23  byte offset from the region start
// ---------------------------------------------------------------------------
module jtvigil_dwnld_map
  import jtvigil_dwnld_pkg::*;
#(
  parameter logic [24:0] BA1_START  = 25'h04_0000,
  parameter logic [24:0] BA2_START  = 25'h06_0000,
  parameter logic [24:0] BA3_START  = 25'h0E_0000,
  parameter logic [24:0] PROM_START = 25'h12_0000
) (
  input  logic [24:0] addr,
  output logic [2:0]  region,
  output logic [1:0]  ba,
  output logic [22:0] offset
);

  localparam logic [24:0] PROM_END = PROM_START + 25'(PROM_SIZE);

  region_t     region_sel;
  logic [22:0] base;

  always_comb begin
    region_sel = RG_DROP;
    ba         = 2'd0;
    base       = PROM_START[22:0];
    if (addr < BA1_START) begin
      region_sel = RG_BA0;
      base       = 23'd0;
    end else if (addr < BA2_START) begin
      region_sel = RG_BA1;
      ba         = 2'd1;
      base       = BA1_START[22:0];
    end else if (addr < BA3_START) begin
      region_sel = RG_BA2;
      ba         = 2'd2;
      base       = BA2_START[22:0];
    end else if (addr < PROM_START) begin
      region_sel = RG_BA3;
      ba         = 2'd3;
      base       = BA3_START[22:0];
    end else if (addr < PROM_END) begin
      region_sel = RG_PROM;
      base       = PROM_START[22:0];
    end
  end

  // Offsets never exceed 23 bits, so subtracting only the low bits is exact.
  assign offset = addr[22:0] - base;
  assign region = region_sel;

endmodule

// File: rtl/jtvigil_dwnld.sv
// ---------------------------------------------------------------------------
// jtvigil_dwnld
// Turns the byte-wide ioctl download stream into word-wide SDRAM programming
// requests (prog_*), with a one-entry buffer for bytes arriving while a write
// is in flight. Colour-PROM bytes bypass the SDRAM path via prom_we.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   downloading, ioctl_addr/dout/wr   download byte stream
//   prog_addr/data/mask/ba/we/rd      SDRAM programming request (held until ack)
//   prog_ack, prog_rdy                arbiter accept / write complete
//   prom_we/addr/data                 one-cycle PROM byte write
//   dwnld_busy                        download active or SDRAM writes pending
//   overflow                          sticky: a byte was lost (buffer full)
// ---------------------------------------------------------------------------
module jtvigil_dwnld
  import jtvigil_dwnld_pkg::*;
#(
  parameter logic [24:0] BA1_START  = 25'h04_0000,
  parameter logic [24:0] BA2_START  = 25'h06_0000,
  parameter logic [24:0] BA3_START  = 25'h0E_0000,
  parameter logic [24:0] PROM_START = 25'h12_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [15:0] prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_ba,
  output logic        prog_we,
  output logic        prog_rd,
  input  logic        prog_ack,
  input  logic        prog_rdy,
  output logic        prom_we,
  output logic [9:0]  prom_addr,
  output logic [7:0]  prom_data,
  output logic        dwnld_busy,
  output logic        overflow
);

  logic [2:0]  map_region;
  logic [1:0]  map_ba;
  logic [22:0] map_offset;

  jtvigil_dwnld_map #(
    .BA1_START  (BA1_START),
    .BA2_START  (BA2_START),
    .BA3_START  (BA3_START),
    .PROM_START (PROM_START)
  ) u_map (
    .addr   (ioctl_addr),
    .region (map_region),
    .ba     (map_ba),
    .offset (map_offset)
  );

  logic    byte_valid;
  logic    fresh_sdram;
  logic    fresh_prom;
  wr_req_t fresh_req;

  assign byte_valid  = downloading & ioctl_wr;
  assign fresh_sdram = byte_valid & (map_region <= 3'(RG_BA3));
  assign fresh_prom  = byte_valid & (map_region == 3'(RG_PROM));
  assign fresh_req   = '{ba: map_ba, addr: map_offset[22:1],
                         data: ioctl_dout, lane: map_offset[0]};

  // State and datapath registers
  state_t      state_reg, state_next;
  wr_req_t     buf_reg, buf_next;
  logic        buf_valid_reg, buf_valid_next;
  logic [21:0] prog_addr_reg;
  logic [15:0] prog_data_reg;
  logic [1:0]  prog_mask_reg;
  logic [1:0]  prog_ba_reg;
  logic        prog_we_reg, we_next;
  logic        prom_we_reg;
  logic [9:0]  prom_addr_reg;
  logic [7:0]  prom_data_reg;
  logic        busy_reg;
  logic        overflow_reg;
  logic        downloading_reg;

  // Control decisions for this cycle
  logic    done;         // current SDRAM write completes this cycle
  logic    start_ok;     // a new request may be loaded this cycle
  logic    load_en;
  wr_req_t load_req;
  logic    draining;     // buffer entry moves to prog_* this cycle
  logic    fresh_taken;  // incoming byte goes straight to prog_*
  logic    ovf_set;

  always_comb begin
    state_next     = state_reg;
    we_next        = prog_we_reg;
    buf_next       = buf_reg;
    buf_valid_next = buf_valid_reg;
    done           = 1'b0;
    start_ok       = 1'b0;
    load_en        = 1'b0;
    load_req       = fresh_req;
    draining       = 1'b0;
    fresh_taken    = 1'b0;
    ovf_set        = 1'b0;

    case (state_reg)
      ST_IDLE: start_ok = 1'b1;
      ST_REQ: begin
        if (prog_ack) begin
          we_next = 1'b0;
          // ack and rdy together: accepted and finished in one cycle
          if (prog_rdy) begin
            done       = 1'b1;
            start_ok   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (prog_rdy) begin
          done       = 1'b1;
          start_ok   = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        we_next    = 1'b0;
      end
    endcase

    // Older buffered byte always goes before a newly arriving one.
    if (start_ok) begin
      if (buf_valid_reg) begin
        load_en        = 1'b1;
        load_req       = buf_reg;
        draining       = 1'b1;
        buf_valid_next = 1'b0;
      end else if (fresh_sdram) begin
        load_en     = 1'b1;
        fresh_taken = 1'b1;
      end
    end

    if (load_en) begin
      state_next = ST_REQ;
      we_next    = 1'b1;
    end

    // A byte that could not start a request is parked; the slot is free if
    // empty or if its occupant is leaving this very cycle.
    if (fresh_sdram && !fresh_taken) begin
      if (!buf_valid_reg || draining) begin
        buf_next       = fresh_req;
        buf_valid_next = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_reg         <= '0;
      buf_valid_reg   <= 1'b0;
      prog_addr_reg   <= 22'd0;
      prog_data_reg   <= 16'd0;
      prog_mask_reg   <= 2'b11;
      prog_ba_reg     <= 2'd0;
      prog_we_reg     <= 1'b0;
      prom_we_reg     <= 1'b0;
      prom_addr_reg   <= 10'd0;
      prom_data_reg   <= 8'd0;
      busy_reg        <= 1'b0;
      overflow_reg    <= 1'b0;
      downloading_reg <= 1'b0;
    end else begin
      buf_reg         <= buf_next;
      buf_valid_reg   <= buf_valid_next;
      prog_we_reg     <= we_next;
      downloading_reg <= downloading;

      // prog_* only change when a new request is loaded, so they stay stable
      // for as long as prog_we is high.
      if (load_en) begin
        prog_addr_reg <= load_req.addr;
        prog_data_reg <= {load_req.data, load_req.data};
        prog_mask_reg <= lane_mask(load_req.lane);
        prog_ba_reg   <= load_req.ba;
      end

      prom_we_reg <= fresh_prom;
      if (fresh_prom) begin
        prom_addr_reg <= map_offset[9:0];
        prom_data_reg <= ioctl_dout;
      end

      // A loss in the same cycle as a new session start is still reported.
      if (ovf_set) begin
        overflow_reg <= 1'b1;
      end else if (downloading && !downloading_reg) begin
        overflow_reg <= 1'b0;
      end

      // Built from next-state values so it falls together with the FSM
      // returning to idle.
      busy_reg <= downloading | (state_next != ST_IDLE) | buf_valid_next;
    end
  end

  assign prog_addr  = prog_addr_reg;
  assign prog_data  = prog_data_reg;
  assign prog_mask  = prog_mask_reg;
  assign prog_ba    = prog_ba_reg;
  assign prog_we    = prog_we_reg;
  assign prog_rd    = 1'b0;
  assign prom_we    = prom_we_reg;
  assign prom_addr  = prom_addr_reg;
  assign prom_data  = prom_data_reg;
  assign dwnld_busy = busy_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_jtvigil_dwnld.sv
// ---------------------------------------------------------------------------
// tb_jtvigil_dwnld
// Directed checks of the download converter followed by a randomized byte
// stream against a capacity-based reference model, with the bench acting as
// the SDRAM arbiter (random ack / rdy delays).
// ---------------------------------------------------------------------------
module tb_jtvigil_dwnld;

  logic        clk;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        prog_rd;
  logic        prog_ack;
  logic        prog_rdy;
  logic        prom_we;
  logic [9:0]  prom_addr;
  logic [7:0]  prom_data;
  logic        dwnld_busy;
  logic        overflow;

  jtvigil_dwnld dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ba     (prog_ba),
    .prog_we     (prog_we),
    .prog_rd     (prog_rd),
    .prog_ack    (prog_ack),
    .prog_rdy    (prog_rdy),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the region table.
  function automatic void decode(input int unsigned a, output int region,
                                 output logic [1:0] ba, output int unsigned off);
    if (a < 32'h40000)       begin region = 0; ba = 2'd0; off = a; end
    else if (a < 32'h60000)  begin region = 1; ba = 2'd1; off = a - 32'h40000; end
    else if (a < 32'hE0000)  begin region = 2; ba = 2'd2; off = a - 32'h60000; end
    else if (a < 32'h120000) begin region = 3; ba = 2'd3; off = a - 32'hE0000; end
    else if (a < 32'h120400) begin region = 4; ba = 2'd0; off = a - 32'h120000; end
    else                     begin region = 5; ba = 2'd0; off = 0; end
  endfunction

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } exp_t;

  exp_t        q[$];
  int unsigned edges[10] = '{32'h3FFFF, 32'h40000, 32'h5FFFF, 32'h60000, 32'hDFFFF,
                             32'hE0000, 32'h11FFFF, 32'h120000, 32'h1203FF, 32'h120400};

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
  endtask

  initial begin
    int          occ, occ_after, arb_phase, cnt, region;
    int unsigned a, off;
    logic [1:0]  ba;
    logic [7:0]  b;
    logic        wr_d, ack_d, rdy_d, exp_ovf, exp_prom, drained;
    logic [9:0]  exp_paddr;
    logic [7:0]  exp_pdata;
    exp_t        e, h;

    rst_n = 1'b0; downloading = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
    ioctl_wr = 1'b0; prog_ack = 1'b0; prog_rdy = 1'b0;

    // Reset values
    tick(); tick();
    check("rst_we", prog_we, 0);
    check("rst_addr", prog_addr, 0);
    check("rst_data", prog_data, 0);
    check("rst_mask", prog_mask, 2'b11);
    check("rst_ba", prog_ba, 0);
    check("rst_prom_we", prom_we, 0);
    check("rst_busy", dwnld_busy, 0);
    check("rst_ovf", overflow, 0);
    check("prog_rd", prog_rd, 0);
    rst_n = 1'b1; downloading = 1'b1;
    tick();
    $display("reset: done");

    // Byte 0x5A at 0x00003
    put_byte(25'h00003, 8'h5A);
    tick(); ioctl_wr = 1'b0;
    check("t1_we", prog_we, 1);
    check("t1_ba", prog_ba, 0);
    check("t1_addr", prog_addr, 1);
    check("t1_data", prog_data, 16'h5A5A);
    check("t1_mask", prog_mask, 2'b01);
    tick(); tick(); tick();
    check("t1_hold", prog_we, 1);
    check("t1_hold_data", prog_data, 16'h5A5A);
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    check("t1_we_drop", prog_we, 0);
    prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
    check("t1_idle", prog_we, 0);
    $display("tx: addr 000003 byte 5a -> bank0 word 1");

    // Byte at 0x06_0004, ack and rdy together
    put_byte(25'h60004, 8'hC3);
    tick(); ioctl_wr = 1'b0;
    check("t2_we", prog_we, 1);
    check("t2_ba", prog_ba, 2);
    check("t2_addr", prog_addr, 2);
    check("t2_mask", prog_mask, 2'b10);
    check("t2_data", prog_data, 16'hC3C3);
    prog_ack = 1'b1; prog_rdy = 1'b1; tick(); prog_ack = 1'b0; prog_rdy = 1'b0;
    check("t2_done", prog_we, 0);
    $display("tx: addr 060004 -> bank2 word 2");

    // PROM byte
    put_byte(25'h120010, 8'h77);
    tick(); ioctl_wr = 1'b0;
    check("t3_prom_we", prom_we, 1);
    check("t3_prom_addr", prom_addr, 10'h010);
    check("t3_prom_data", prom_data, 8'h77);
    check("t3_prog_we", prog_we, 0);
    tick();
    check("t3_prom_pulse", prom_we, 0);
    // Above the PROM window: discarded
    put_byte(25'h120400, 8'h11);
    tick(); ioctl_wr = 1'b0;
    check("t3_drop_we", prog_we, 0);
    check("t3_drop_prom", prom_we, 0);
    $display("tx: prom 010 byte 77, drop at 120400");

    // Three bytes back to back, slow ack
    put_byte(25'h00010, 8'hA1); tick();
    put_byte(25'h00011, 8'hB2); tick();
    check("t4_we", prog_we, 1);
    put_byte(25'h00012, 8'hC3); tick();
    ioctl_wr = 1'b0; tick();
    check("t4_ovf", overflow, 1);
    check("t4_a_data", prog_data, 16'hA1A1);
    check("t4_a_mask", prog_mask, 2'b10);
    tick(); tick();
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    check("t4_a_acked", prog_we, 0);
    prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
    check("t4_b_we", prog_we, 1);
    check("t4_b_data", prog_data, 16'hB2B2);
    check("t4_b_addr", prog_addr, 8);
    check("t4_b_mask", prog_mask, 2'b01);
    prog_ack = 1'b1; prog_rdy = 1'b1; tick(); prog_ack = 1'b0; prog_rdy = 1'b0;
    tick();
    check("t4_no_third", prog_we, 0);
    downloading = 1'b0; tick();
    check("t4_ovf_sticky", overflow, 1);
    downloading = 1'b1; tick();
    check("t4_ovf_clear", overflow, 0);
    $display("tx: burst of three, third dropped, overflow cleared on new session");

    // Reset while waiting for rdy with the buffer occupied
    put_byte(25'h40002, 8'h31); tick();
    prog_ack = 1'b1; put_byte(25'h40003, 8'h32); tick();
    prog_ack = 1'b0; ioctl_wr = 1'b0; tick();
    check("t5_wait_we", prog_we, 0);
    check("t5_wait_busy", dwnld_busy, 1);
    downloading = 1'b0; rst_n = 1'b0; #1;
    check("t5_rst_we", prog_we, 0);
    check("t5_rst_busy", dwnld_busy, 0);
    check("t5_rst_mask", prog_mask, 2'b11);
    tick(); rst_n = 1'b1;
    tick(); tick();
    check("t5_no_replay", prog_we, 0);
    check("t5_buf_empty", dwnld_busy, 0);
    $display("tx: reset in WAIT aborts transfer");

    // downloading falls with a write pending
    downloading = 1'b1; tick();
    put_byte(25'hE0006, 8'h44); tick();
    ioctl_wr = 1'b0; downloading = 1'b0;
    check("t6_ba", prog_ba, 3);
    check("t6_addr", prog_addr, 3);
    tick();
    check("t6_busy_req", dwnld_busy, 1);
    prog_ack = 1'b1; tick(); prog_ack = 1'b0;
    check("t6_busy_wait", dwnld_busy, 1);
    prog_rdy = 1'b1; tick(); prog_rdy = 1'b0;
    check("t6_busy_end", dwnld_busy, 0);
    put_byte(25'h00005, 8'h99); tick(); ioctl_wr = 1'b0;
    check("t6_ignored", prog_we, 0);
    check("t6_ignored_busy", dwnld_busy, 0);
    $display("tx: busy held until rdy; byte ignored while not downloading");

    // Randomized stream, bench as arbiter
    downloading = 1'b1; tick();
    occ = 0; arb_phase = 0; cnt = 0; exp_ovf = 1'b0; exp_prom = 1'b0;
    exp_paddr = '0; exp_pdata = '0; drained = 1'b0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      check("r_ovf", overflow, exp_ovf);
      check("r_busy", dwnld_busy, 1);
      check("r_prom_we", prom_we, exp_prom);
      if (exp_prom) begin
        check("r_prom_addr", prom_addr, exp_paddr);
        check("r_prom_data", prom_data, exp_pdata);
      end
      if (cyc >= 3000 && occ == 0 && arb_phase == 0) begin
        drained = 1'b1;
        break;
      end
      ack_d = 1'b0; rdy_d = 1'b0;
      if (arb_phase == 0) begin
        check("r_we_idle", prog_we, (occ > 0));
        if (prog_we) begin
          arb_phase = 1;
          cnt = $urandom_range(0, 3);
        end
      end else if (arb_phase == 2) begin
        check("r_we_wait", prog_we, 0);
        cnt--;
        if (cnt == 0) begin
          rdy_d = 1'b1;
          arb_phase = 0;
        end
      end
      if (arb_phase == 1) begin
        check("r_we_hold", prog_we, 1);
        if (cnt == 0) begin
          ack_d = 1'b1;
          check("r_req_expected", (q.size() != 0), 1);
          if (q.size() != 0) begin
            h = q.pop_front();
            check("r_ba", prog_ba, h.ba);
            check("r_addr", prog_addr, h.addr);
            check("r_data", prog_data, h.data);
            check("r_mask", prog_mask, h.mask);
            $display("tx: write ba %0d addr %06h data %04h mask %02b", h.ba, h.addr, h.data, h.mask);
          end
          cnt = $urandom_range(0, 3);
          if (cnt == 0) begin
            rdy_d = 1'b1;
            arb_phase = 0;
          end else begin
            arb_phase = 2;
          end
        end else begin
          cnt--;
        end
      end

      wr_d = (cyc < 3000) && ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 6))
        0: a = $urandom_range(0, 32'h3FFFF);
        1: a = 32'h40000 + $urandom_range(0, 32'h1FFFF);
        2: a = 32'h60000 + $urandom_range(0, 32'h7FFFF);
        3: a = 32'hE0000 + $urandom_range(0, 32'h3FFFF);
        4: a = 32'h120000 + $urandom_range(0, 1023);
        5: a = 32'h120400 + $urandom_range(0, 32'h1FFFF);
        default: a = edges[$urandom_range(0, 9)];
      endcase
      b = 8'($urandom);

      // Capacity model: one write in flight plus one buffered byte; a
      // completion this cycle frees a slot before the new byte is judged.
      occ_after = occ - int'(rdy_d);
      exp_prom = 1'b0;
      if (wr_d) begin
        decode(a, region, ba, off);
        if (region == 4) begin
          exp_prom  = 1'b1;
          exp_paddr = 10'(off);
          exp_pdata = b;
        end else if (region < 4) begin
          if (occ_after < 2) begin
            e.ba   = ba;
            e.addr = 22'(off >> 1);
            e.data = {b, b};
            e.mask = off[0] ? 2'b01 : 2'b10;
            q.push_back(e);
            occ_after++;
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
      occ = occ_after;

      ioctl_addr = 25'(a);
      ioctl_dout = b;
      ioctl_wr   = wr_d;
      prog_ack   = ack_d;
      prog_rdy   = rdy_d;
    end
    ioctl_wr = 1'b0; prog_ack = 1'b0; prog_rdy = 1'b0;
    check("r_drain", drained, 1);
    tick();
    check("r_final_we", prog_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
